reserv_station: RTL and testbench

Generic, parametrised reservation station for the execute stage: accepts dispatched instructions carrying an op, a destination tag and up to two source operands, holds them until every operand has been captured from the ROB/result broadcast buses, then issues one ready instruction per cycle to its execution unit over a valid/ready handshake. It replaces the fixed per-unit stations (ALU, forwarder) with one configurable block instantiated once per execution unit inside the execute stage.

---
 rtl/rs_pkg.sv | 29 ++
 rtl/rs_if.sv | 35 +++
 rtl/rs_select.sv | 43 ++++
 rtl/reserv_station.sv | 178 +++++++++++++++++
 tb/tb_reserv_station.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared defaults, entry/broadcast types and tag helper for the reservation station.
package rs_pkg;

    localparam int RS_DEPTH     = 4;
    localparam int RS_DATA_W    = 32;
    localparam int RS_TAG_W     = 5;
    localparam int RS_OP_W      = 4;
    localparam int RS_BCAST_NUM = 2;

    localparam logic [RS_TAG_W-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic                           valid;
        logic [RS_OP_W-1:0]             op;
        logic [RS_TAG_W-1:0]            target;
        logic [1:0][RS_TAG_W-1:0]       tag;
        logic [1:0][RS_DATA_W-1:0]      val;
    } rs_entry_t;

    typedef struct packed {
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_DATA_W-1:0] val;
    } rs_bcast_t;

    function automatic logic tag_is_invalid(input logic [RS_TAG_W-1:0] t);
        return t == TAG_INVALID;
    endfunction

endpackage

// File: rtl/rs_if.sv
// Dispatch, broadcast-snoop and issue bundle between the execute stage and one station.
interface rs_if
    import rs_pkg::*;
#(
    parameter int DATA_W    = RS_DATA_W,
    parameter int TAG_W     = RS_TAG_W,
    parameter int OP_W      = RS_OP_W,
    parameter int BCAST_NUM = RS_BCAST_NUM
);
    logic              in_ce;
    logic [TAG_W-1:0]  in_target;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_val [1:2];
    logic [TAG_W-1:0]  in_tag [1:2];
    logic [TAG_W-1:0]  bc_tag [0:BCAST_NUM-1];
    logic [DATA_W-1:0] bc_val [0:BCAST_NUM-1];
    logic              flush;
    logic              full;
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_target;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_val [1:2];

    modport master (
        output in_ce, in_target, in_op, in_val, in_tag, bc_tag, bc_val, flush, issue_ready,
        input  full, issue_valid, issue_target, issue_op, issue_val
    );

    modport slave (
        input  in_ce, in_target, in_op, in_val, in_tag, bc_tag, bc_val, flush, issue_ready,
        output full, issue_valid, issue_target, issue_op, issue_val
    );

endinterface

// File: rtl/rs_select.sv
// Picks one ready entry: oldest by age matrix with RS_OLDEST_FIRST_EN, lowest index otherwise.
module rs_select
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic [DEPTH-1:0]            ready,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
    output logic [DEPTH-1:0]            grant,
    output logic                        grant_valid
);

`ifdef RS_OLDEST_FIRST_EN
    // older[j][i] set means j was dispatched before i; grant the ready entry no ready entry beats.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i]) begin
                grant[i] = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if (ready[j] && older[j][i]) begin
                        grant[i] = 1'b0;
                    end
                end
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                grant = DEPTH'(1) << i;
            end
        end
    end
`endif

    assign grant_valid = |ready;

endmodule

// File: rtl/reserv_station.sv
// Generic reservation station: holds dispatched ops until operands arrive, issues one per cycle.
// Define RS_OLDEST_FIRST_EN for oldest-ready selection instead of lowest-index.
module reserv_station
    import rs_pkg::*;
#(
    parameter int DEPTH     = RS_DEPTH,
    parameter int DATA_W    = RS_DATA_W,
    parameter int TAG_W     = RS_TAG_W,
    parameter int OP_W      = RS_OP_W,
    parameter int BCAST_NUM = RS_BCAST_NUM
) (
    input logic clk,
    input logic rst,
    rs_if.slave rs
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] TAG_INV = '1;

    typedef struct packed {
        logic                     valid;
        logic [OP_W-1:0]          op;
        logic [TAG_W-1:0]         target;
        logic [1:0][TAG_W-1:0]    tag;
        logic [1:0][DATA_W-1:0]   val;
    } entry_t;

    entry_t [DEPTH-1:0]     ent_q, ent_d;
    logic                   out_valid_q, out_valid_d;
    logic [TAG_W-1:0]       out_target_q, out_target_d;
    logic [OP_W-1:0]        out_op_q, out_op_d;
    logic [1:0][DATA_W-1:0] out_val_q, out_val_d;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic             grant_valid;
    logic             free_valid;
    logic [IDX_W-1:0] free_idx;
    logic             full;
    logic             can_issue;
    logic             dispatch_en;

    always_comb begin
        ready      = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = ent_q[i].valid && (ent_q[i].tag[0] == TAG_INV) && (ent_q[i].tag[1] == TAG_INV);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign full        = !free_valid;
    assign can_issue   = grant_valid && (!out_valid_q || rs.issue_ready);
    assign dispatch_en = rs.in_ce && (rs.in_target != TAG_INV) && !full;

`ifdef RS_OLDEST_FIRST_EN
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

    // A new entry is younger than everything already held; its own row is cleared.
    always_comb begin
        older_d = older_q;
        if (dispatch_en && !rs.flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                older_d[free_idx][j] = 1'b0;
                older_d[j][free_idx] = (j != int'(free_idx));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`endif

    rs_select #(
        .DEPTH       (DEPTH)
    ) u_select (
        .ready       (ready),
`ifdef RS_OLDEST_FIRST_EN
        .older       (older_q),
`endif
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        ent_d        = ent_q;
        out_valid_d  = out_valid_q;
        out_target_d = out_target_q;
        out_op_d     = out_op_q;
        out_val_d    = out_val_q;

        // Downward bus scan so the lowest-index matching bus is written last and wins.
        for (int i = 0; i < DEPTH; i++) begin
            for (int o = 0; o < 2; o++) begin
                if (ent_q[i].valid && (ent_q[i].tag[o] != TAG_INV)) begin
                    for (int b = BCAST_NUM - 1; b >= 0; b--) begin
                        if (rs.bc_tag[b] == ent_q[i].tag[o]) begin
                            ent_d[i].tag[o] = TAG_INV;
                            ent_d[i].val[o] = rs.bc_val[b];
                        end
                    end
                end
            end
        end

        if (can_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[i]) begin
                    out_target_d   = ent_q[i].target;
                    out_op_d       = ent_q[i].op;
                    out_val_d      = ent_q[i].val;
                    ent_d[i].valid = 1'b0;
                end
            end
            out_valid_d = 1'b1;
        end else if (rs.issue_ready) begin
            out_valid_d = 1'b0;
        end

        if (dispatch_en) begin
            ent_d[free_idx].valid  = 1'b1;
            ent_d[free_idx].op     = rs.in_op;
            ent_d[free_idx].target = rs.in_target;
            for (int o = 0; o < 2; o++) begin
                ent_d[free_idx].tag[o] = rs.in_tag[o+1];
                ent_d[free_idx].val[o] = rs.in_val[o+1];
                for (int b = BCAST_NUM - 1; b >= 0; b--) begin
                    if ((rs.in_tag[o+1] != TAG_INV) && (rs.bc_tag[b] == rs.in_tag[o+1])) begin
                        ent_d[free_idx].tag[o] = TAG_INV;
                        ent_d[free_idx].val[o] = rs.bc_val[b];
                    end
                end
            end
        end

        if (rs.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q        <= '0;
            out_valid_q  <= 1'b0;
            out_target_q <= TAG_INV;
            out_op_q     <= '0;
            out_val_q    <= '0;
        end else begin
            ent_q        <= ent_d;
            out_valid_q  <= out_valid_d;
            out_target_q <= out_target_d;
            out_op_q     <= out_op_d;
            out_val_q    <= out_val_d;
        end
    end

    assign rs.full         = full;
    assign rs.issue_valid  = out_valid_q;
    assign rs.issue_target = out_target_q;
    assign rs.issue_op     = out_op_q;
    assign rs.issue_val[1] = out_val_q[0];
    assign rs.issue_val[2] = out_val_q[1];

endmodule

// File: tb/tb_reserv_station.sv
// Scoreboard bench for reserv_station: random and directed traffic against a slot-level model.
module tb_reserv_station;
    import rs_pkg::*;

    localparam int DEPTH = RS_DEPTH;
    localparam logic [RS_TAG_W-1:0] INV = TAG_INVALID;

    typedef struct packed {
        logic                      reset;
        logic                      flush;
        logic                      ready;
        logic                      ce;
        logic [RS_TAG_W-1:0]       target;
        logic [RS_OP_W-1:0]        op;
        logic [1:0][RS_TAG_W-1:0]  tag;
        logic [1:0][RS_DATA_W-1:0] val;
        rs_bcast_t [1:0]           bc;
    } stim_t;

    typedef struct packed {
        logic [RS_TAG_W-1:0]       target;
        logic [RS_OP_W-1:0]        op;
        logic [1:0][RS_DATA_W-1:0] val;
    } pay_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rs_if #(
        .DATA_W    (RS_DATA_W),
        .TAG_W     (RS_TAG_W),
        .OP_W      (RS_OP_W),
        .BCAST_NUM (RS_BCAST_NUM)
    ) bus ();

    reserv_station #(
        .DEPTH     (DEPTH),
        .DATA_W    (RS_DATA_W),
        .TAG_W     (RS_TAG_W),
        .OP_W      (RS_OP_W),
        .BCAST_NUM (RS_BCAST_NUM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
    );

    // Reference model: the station contents as a list of slots plus a dispatch sequence number.
    rs_entry_t mdl [DEPTH];
    int        mdl_seq [DEPTH];
    int        seq_ctr = 0;
    bit        m_out_valid = 1'b0;
    pay_t      exp_q [$];

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s        = '0;
        s.ready  = 1'b1;
        s.target = INV;
        s.tag[0] = INV;
        s.tag[1] = INV;
        s.bc[0].tag = INV;
        s.bc[1].tag = INV;
        return s;
    endfunction

    function automatic bit modelFull();
        for (int i = 0; i < DEPTH; i++) begin
            if (!mdl[i].valid) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelStep(input stim_t s);
        rs_entry_t nxt [DEPTH];
        int        pick;
        int        slot;
        bit        was_full;
        pay_t      p;
        if (s.reset || s.flush) begin
            for (int i = 0; i < DEPTH; i++) mdl[i].valid = 1'b0;
            m_out_valid = 1'b0;
            exp_q.delete();
            return;
        end
        was_full = modelFull();
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mdl[i].valid && tag_is_invalid(mdl[i].tag[0]) && tag_is_invalid(mdl[i].tag[1])) begin
`ifdef RS_OLDEST_FIRST_EN
                if (pick < 0 || mdl_seq[i] < mdl_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        nxt = mdl;
        for (int i = 0; i < DEPTH; i++) begin
            for (int o = 0; o < 2; o++) begin
                if (mdl[i].valid && !tag_is_invalid(mdl[i].tag[o])) begin
                    for (int b = 0; b < 2; b++) begin
                        if (s.bc[b].tag == mdl[i].tag[o]) begin
                            nxt[i].tag[o] = INV;
                            nxt[i].val[o] = s.bc[b].val;
                            break;
                        end
                    end
                end
            end
        end
        if (pick >= 0 && (!m_out_valid || s.ready)) begin
            p.target = mdl[pick].target;
            p.op     = mdl[pick].op;
            p.val    = mdl[pick].val;
            exp_q.push_back(p);
            nxt[pick].valid = 1'b0;
            m_out_valid = 1'b1;
        end else if (s.ready) begin
            m_out_valid = 1'b0;
        end
        if (s.ce && !tag_is_invalid(s.target) && !was_full) begin
            slot = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (!mdl[i].valid && slot < 0) slot = i;
            end
            nxt[slot].valid  = 1'b1;
            nxt[slot].op     = s.op;
            nxt[slot].target = s.target;
            for (int o = 0; o < 2; o++) begin
                nxt[slot].tag[o] = s.tag[o];
                nxt[slot].val[o] = s.val[o];
                if (!tag_is_invalid(s.tag[o])) begin
                    for (int b = 0; b < 2; b++) begin
                        if (s.bc[b].tag == s.tag[o]) begin
                            nxt[slot].tag[o] = INV;
                            nxt[slot].val[o] = s.bc[b].val;
                            break;
                        end
                    end
                end
            end
            mdl_seq[slot] = seq_ctr;
            seq_ctr++;
        end
        mdl = nxt;
    endtask

    task automatic driveBus(input stim_t s);
        rst             = s.reset;
        bus.flush       = s.flush;
        bus.issue_ready = s.ready;
        bus.in_ce       = s.ce;
        bus.in_target   = s.target;
        bus.in_op       = s.op;
        bus.in_tag[1]   = s.tag[0];
        bus.in_tag[2]   = s.tag[1];
        bus.in_val[1]   = s.val[0];
        bus.in_val[2]   = s.val[1];
        bus.bc_tag[0]   = s.bc[0].tag;
        bus.bc_val[0]   = s.bc[0].val;
        bus.bc_tag[1]   = s.bc[1].tag;
        bus.bc_val[1]   = s.bc[1].val;
    endtask

    task automatic checkOutput();
        checkValue("full", 64'(bus.full), 64'(modelFull()));
        checkValue("issue_valid", 64'(bus.issue_valid), 64'(m_out_valid));
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        checkOutput();
        driveBus(s);
        modelStep(s);
    endtask

    // Monitor: pops the scoreboard on every accepted issue and checks held payloads stay put.
    initial begin
        pay_t cur;
        pay_t last;
        pay_t e;
        bit   hold;
        hold = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            #1;
            cur.target = bus.issue_target;
            cur.op     = bus.issue_op;
            cur.val[0] = bus.issue_val[1];
            cur.val[1] = bus.issue_val[2];
            if (hold && bus.issue_valid) begin
                checkValue("stable_target", 64'(cur.target), 64'(last.target));
                checkValue("stable_val1", 64'(cur.val[0]), 64'(last.val[0]));
            end
            hold = bus.issue_valid && !bus.issue_ready;
            last = cur;
            if (bus.issue_valid && bus.issue_ready && !rst && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    checkValue("unexpected_issue", 64'(cur.target), 64'(INV));
                end else begin
                    e = exp_q.pop_front();
                    checkValue("issue_target", 64'(cur.target), 64'(e.target));
                    checkValue("issue_op", 64'(cur.op), 64'(e.op));
                    checkValue("issue_val1", 64'(cur.val[0]), 64'(e.val[0]));
                    checkValue("issue_val2", 64'(cur.val[1]), 64'(e.val[1]));
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = idleStim();
        s.reset = 1'b1;
        s.ready = 1'b0;
        driveBus(s);
        modelStep(s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
        checkValue("reset_full", 64'(bus.full), 64'd0);
        checkValue("reset_issue_target", 64'(bus.issue_target), 64'(INV));
        checkValue("reset_issue_op", 64'(bus.issue_op), 64'd0);
        checkValue("reset_issue_val", 64'({bus.issue_val[1], bus.issue_val[2]}), 64'd0);

        $display("[TB] ready operands dispatch");
        s = idleStim(); s.ce = 1'b1; s.target = 5'd3; s.op = 4'd1; s.val[0] = 32'd5; s.val[1] = 32'd7;
        applyStimulus(s);
        repeat (3) applyStimulus(idleStim());

        $display("[TB] wakeup by broadcast");
        s = idleStim(); s.ce = 1'b1; s.target = 5'd6; s.op = 4'd2; s.tag[0] = 5'd2; s.val[1] = 32'd9;
        applyStimulus(s);
        repeat (2) applyStimulus(idleStim());
        s = idleStim(); s.bc[0].tag = 5'd2; s.bc[0].val = 32'hAA;
        applyStimulus(s);
        repeat (3) applyStimulus(idleStim());

        $display("[TB] dispatch bypass");
        s = idleStim(); s.ce = 1'b1; s.target = 5'd8; s.op = 4'd3; s.tag[1] = 5'd4; s.val[0] = 32'd1;
        s.bc[0].tag = 5'd4; s.bc[0].val = 32'h55; s.bc[1].tag = 5'd4; s.bc[1].val = 32'h66;
        applyStimulus(s);
        repeat (3) applyStimulus(idleStim());

        $display("[TB] fill, drop, hold");
        for (int i = 0; i < DEPTH; i++) begin
            s = idleStim(); s.ready = 1'b0; s.ce = 1'b1; s.target = 5'(10 + i); s.op = 4'(i);
            s.tag[0] = 5'(20 + i); s.val[1] = 32'(100 + i);
            applyStimulus(s);
        end
        s = idleStim(); s.ready = 1'b0; s.ce = 1'b1; s.target = 5'd14; s.op = 4'd9;
        applyStimulus(s);
        s = idleStim(); s.ready = 1'b0; s.bc[1].tag = 5'd22; s.bc[1].val = 32'h222;
        applyStimulus(s);
        s = idleStim(); s.ready = 1'b0; s.bc[0].tag = 5'd20; s.bc[0].val = 32'h200;
        applyStimulus(s);
        s = idleStim(); s.ready = 1'b0;
        repeat (3) applyStimulus(s);
        repeat (3) applyStimulus(idleStim());
        s = idleStim(); s.bc[0].tag = 5'd21; s.bc[0].val = 32'h211; s.bc[1].tag = 5'd23; s.bc[1].val = 32'h233;
        applyStimulus(s);
        repeat (4) applyStimulus(idleStim());

        $display("[TB] flush");
        for (int i = 0; i < 2; i++) begin
            s = idleStim(); s.ready = 1'b0; s.ce = 1'b1; s.target = 5'(15 + i); s.val[0] = 32'(i);
            applyStimulus(s);
        end
        s = idleStim(); s.ready = 1'b0; s.flush = 1'b1; s.ce = 1'b1; s.target = 5'd17;
        applyStimulus(s);
        applyStimulus(idleStim());
        s = idleStim(); s.ce = 1'b1; s.target = 5'd18; s.op = 4'd5; s.val[0] = 32'h18;
        applyStimulus(s);
        repeat (3) applyStimulus(idleStim());

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            s = idleStim();
            s.ce     = ($urandom_range(0, 3) != 0);
            s.target = ($urandom_range(0, 7) == 0) ? INV : 5'($urandom_range(0, 30));
            s.op     = 4'($urandom_range(0, 15));
            for (int o = 0; o < 2; o++) begin
                s.tag[o] = ($urandom_range(0, 1) == 0) ? INV : 5'($urandom_range(0, 7));
                s.val[o] = $urandom;
            end
            for (int b = 0; b < 2; b++) begin
                s.bc[b].tag = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : INV;
                s.bc[b].val = $urandom;
            end
            s.ready = ($urandom_range(0, 3) != 0);
            s.flush = ($urandom_range(0, 59) == 0);
            s.reset = ($urandom_range(0, 149) == 0);
            if (s.flush || s.reset) s.ready = 1'b0;
            applyStimulus(s);
        end

        $display("[TB] drain");
        for (int t = 0; t < 8; t++) begin
            s = idleStim(); s.bc[0].tag = 5'(t); s.bc[0].val = 32'(1000 + t);
            applyStimulus(s);
        end
        repeat (10) applyStimulus(idleStim());
        @(negedge clk);
        checkOutput();
        #2;
        checkValue("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
